// File: rtl/branch_resolver.sv
// Branch resolver: consumer end of the backup-PC FIFO.
// Tracks one prediction bit per outstanding branch, pops the backup FIFO when
// the oldest branch resolves, and on a misprediction redirects fetch to the
// backup PC, flushes the pipeline and clears the FIFO.
module branch_resolver #(
    parameter int PC_W         = 11,
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            br_issue,
    input  logic            pred_taken,
    input  logic            br_resolve,
    input  logic            actual_taken,
    input  logic [PC_W-1:0] fifo_head,
    output logic            fifo_pop,
    output logic            fifo_clear,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            stall_issue,
    output logic            overflow_err,
    output logic            underflow_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state;
    logic [DEPTH-1:0] pred_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [FW-1:0]   flush_cnt;

    logic is_idle;
    logic issue_ok;
    logic issue_blocked;
    logic resolve_ok;
    logic resolve_empty;
    logic mispredict;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue/resolve acceptance and hazard decode
    always_comb begin
        is_idle       = (state == IDLE);
        stall_issue   = !is_idle || (count == CW'(DEPTH));
        issue_ok      = br_issue && !stall_issue;
        issue_blocked = br_issue && stall_issue && is_idle;
        resolve_ok    = br_resolve && is_idle && (count != '0);
        resolve_empty = br_resolve && is_idle && (count == '0);
        mispredict    = resolve_ok && (actual_taken != pred_q[rd_ptr]);
        fifo_pop      = resolve_ok;
    end

    // Prediction queue, occupancy, redirect/flush FSM and sticky error flags
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state         <= IDLE;
            pred_q        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            flush_cnt     <= '0;
            fifo_clear    <= 1'b0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            flush         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (issue_blocked) overflow_err  <= 1'b1;
            if (resolve_empty) underflow_err <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (mispredict) begin
                        // A same-cycle accepted issue is deliberately dropped here.
                        redirect_pc <= fifo_head;
                        count       <= '0;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        redirect    <= 1'b1;
                        fifo_clear  <= 1'b1;
                        flush       <= 1'b1;
                        flush_cnt   <= FW'(FLUSH_CYCLES - 1);
                        state       <= REDIRECT;
                    end else begin
                        if (issue_ok) begin
                            pred_q[wr_ptr] <= pred_taken;
                            wr_ptr         <= ptr_next(wr_ptr);
                        end
                        if (resolve_ok) rd_ptr <= ptr_next(rd_ptr);
                        if (issue_ok && !resolve_ok)
                            count <= count + 1'b1;
                        else if (!issue_ok && resolve_ok)
                            count <= count - 1'b1;
                    end
                end
                REDIRECT, FLUSH: begin
                    // flush_cnt holds the flush-high cycles remaining after this one.
                    redirect   <= 1'b0;
                    fifo_clear <= 1'b0;
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                        state     <= FLUSH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (default parameters).
// Expected redirect PCs are queued when a mispredicting resolve is driven and
// consumed when the redirect strobe is observed.
module tb_branch_resolver;

    localparam int PC_W = 11;

    logic            clk;
    logic            clear;
    logic            br_issue;
    logic            pred_taken;
    logic            br_resolve;
    logic            actual_taken;
    logic [PC_W-1:0] fifo_head;
    logic            fifo_pop;
    logic            fifo_clear;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic            stall_issue;
    logic            overflow_err;
    logic            underflow_err;

    int vectors = 0;
    int miscompares = 0;

    logic [PC_W-1:0] exp_pc_q[$];
    logic [PC_W-1:0] exp_pc;

    branch_resolver #(.PC_W(PC_W), .DEPTH(2), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .clear        (clear),
        .br_issue     (br_issue),
        .pred_taken   (pred_taken),
        .br_resolve   (br_resolve),
        .actual_taken (actual_taken),
        .fifo_head    (fifo_head),
        .fifo_pop     (fifo_pop),
        .fifo_clear   (fifo_clear),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .stall_issue  (stall_issue),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, then settle so combinational outputs can be sampled
    task automatic drive(input logic bi, input logic pt, input logic br, input logic at,
                         input logic [PC_W-1:0] head);
        @(negedge clk);
        br_issue     = bi;
        pred_taken   = pt;
        br_resolve   = br;
        actual_taken = at;
        fifo_head    = head;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redirect(input string tag);
        if (exp_pc_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_pc = exp_pc_q.pop_front();
            chk({tag, "_redirect"}, redirect, 1'b1);
            chk({tag, "_redirect_pc"}, redirect_pc, exp_pc);
            chk({tag, "_fifo_clear"}, fifo_clear, 1'b1);
            chk({tag, "_flush"}, flush, 1'b1);
        end
    endtask

    initial begin
        clear = 1'b1;
        br_issue = 1'b0; pred_taken = 1'b0; br_resolve = 1'b0;
        actual_taken = 1'b0; fifo_head = '0;

        // 1 Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_during", stall_issue, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("rst_pop", fifo_pop, 1'b0);
        chk("rst_fifo_clear", fifo_clear, 1'b0);
        chk("rst_redirect", redirect, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 11'h000);
        chk("rst_flush", flush, 1'b0);
        chk("rst_stall", stall_issue, 1'b0);
        chk("rst_ovf", overflow_err, 1'b0);
        chk("rst_udf", underflow_err, 1'b0);

        // 2 Correct prediction
        drive(1, 1, 0, 0, 11'h000);
        chk("c_issue_nopop", fifo_pop, 1'b0);
        tick();
        drive(0, 0, 1, 1, 11'h155);
        chk("c_pop", fifo_pop, 1'b1);
        tick();
        chk("c_no_redirect", redirect, 1'b0);
        chk("c_no_flush", flush, 1'b0);
        drive(0, 0, 0, 0, 11'h000);
        chk("c_stall_low", stall_issue, 1'b0);
        chk("c_udf_clean", underflow_err, 1'b0);

        // 3 Mispredict: oldest prediction 0, outcome 1
        drive(1, 0, 0, 0, 11'h000);
        tick();
        drive(1, 1, 0, 0, 11'h000);
        tick();
        drive(0, 0, 1, 1, 11'h2A0);
        chk("m_stall_full", stall_issue, 1'b1);
        chk("m_pop", fifo_pop, 1'b1);
        exp_pc_q.push_back(11'h2A0);
        tick();
        expect_redirect("m");
        chk("m_stall_redir", stall_issue, 1'b1);
        // wrong-path issue during REDIRECT is silently ignored
        drive(1, 1, 1, 0, 11'h000);
        chk("m_pop_redir", fifo_pop, 1'b0);
        tick();
        chk("m_redirect_1cyc", redirect, 1'b0);
        chk("m_fifo_clear_1cyc", fifo_clear, 1'b0);
        chk("m_flush2", flush, 1'b1);
        chk("m_stall_flush", stall_issue, 1'b1);
        chk("m_ovf_silent", overflow_err, 1'b0);
        chk("m_udf_silent", underflow_err, 1'b0);
        drive(0, 0, 0, 0, 11'h000);
        tick();
        chk("m_flush_end", flush, 1'b0);
        chk("m_stall_end", stall_issue, 1'b0);
        chk("m_pc_hold", redirect_pc, 11'h2A0);

        // 4 Full / overflow / simultaneous issue+resolve
        drive(1, 1, 0, 0, 11'h000);
        chk("f_stall0", stall_issue, 1'b0);
        tick();
        chk("f_stall1", stall_issue, 1'b0);
        drive(1, 1, 0, 0, 11'h000);
        tick();
        chk("f_stall2", stall_issue, 1'b1);
        drive(1, 0, 0, 0, 11'h000);
        tick();
        chk("f_ovf", overflow_err, 1'b1);
        chk("f_still_full", stall_issue, 1'b1);
        drive(0, 0, 1, 1, 11'h100);
        chk("f_pop_a", fifo_pop, 1'b1);
        tick();
        chk("f_count1", stall_issue, 1'b0);
        chk("f_no_redirect_a", redirect, 1'b0);
        drive(1, 1, 1, 1, 11'h101);
        chk("f_pop_both", fifo_pop, 1'b1);
        tick();
        chk("f_count_kept", stall_issue, 1'b0);
        chk("f_no_redirect_b", redirect, 1'b0);
        drive(1, 1, 0, 0, 11'h000);
        tick();
        chk("f_count2_again", stall_issue, 1'b1);
        drive(0, 0, 1, 1, 11'h102);
        chk("f_pop_c", fifo_pop, 1'b1);
        tick();
        drive(0, 0, 1, 1, 11'h103);
        chk("f_pop_d", fifo_pop, 1'b1);
        tick();
        chk("f_no_redirect_d", redirect, 1'b0);

        // 5 Underflow
        drive(0, 0, 1, 0, 11'h000);
        chk("u_nopop", fifo_pop, 1'b0);
        tick();
        chk("u_flag", underflow_err, 1'b1);
        chk("u_no_redirect", redirect, 1'b0);
        drive(0, 0, 0, 0, 11'h000);
        tick();
        chk("u_sticky", underflow_err, 1'b1);
        chk("u_ovf_sticky", overflow_err, 1'b1);

        // 6 Reset during FLUSH
        drive(1, 1, 0, 0, 11'h000);
        tick();
        drive(0, 0, 1, 0, 11'h3FF);
        chk("r_pop", fifo_pop, 1'b1);
        exp_pc_q.push_back(11'h3FF);
        tick();
        expect_redirect("r");
        drive(0, 0, 0, 0, 11'h000);
        tick();
        chk("r_in_flush", flush, 1'b1);
        #2;
        clear = 1'b1;
        #1;
        chk("r_flush_abort", flush, 1'b0);
        chk("r_stall_idle", stall_issue, 1'b0);
        chk("r_pc_cleared", redirect_pc, 11'h000);
        chk("r_ovf_cleared", overflow_err, 1'b0);
        chk("r_udf_cleared", underflow_err, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        drive(1, 0, 0, 0, 11'h000);
        tick();
        chk("r_count1", stall_issue, 1'b0);
        drive(1, 0, 0, 0, 11'h000);
        tick();
        chk("r_count2", stall_issue, 1'b1);
        drive(0, 0, 0, 0, 11'h000);
        chk("r_sb_drained", exp_pc_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
